// File: rtl/key_event_pkg.sv
// Shared types for the keypad event decoder: FSM states, note range and control actions.
// Pure declarations; no timing or flow control of its own.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NOTE_HELD,
    CTRL_HELD
  } state_t;

  localparam logic [3:0] NOTE_MAX = 4'd12;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_UP,
    ACT_DOWN,
    ACT_MODE,
    ACT_GOOF
  } action_t;

  // Winning control flag when several are held: up > down > mode > goof.
  function automatic action_t pick_action(input logic up, input logic down,
                                          input logic mode, input logic goof);
    action_t act;
    act = ACT_NONE;
    if (up)        act = ACT_UP;
    else if (down) act = ACT_DOWN;
    else if (mode) act = ACT_MODE;
    else if (goof) act = ACT_GOOF;
    return act;
  endfunction

endpackage

// File: rtl/key_action_regs.sv
// Octave (saturating), mode (wrapping) and goof toggle registers, updated by a one-cycle action strobe.
// Latency: the register changes on the clock edge that samples act_vld; no backpressure.
module key_action_regs
  import key_event_pkg::*;
#(
  parameter int unsigned OCT_W      = 3,
  parameter int unsigned OCT_MAX    = 6,
  parameter int unsigned OCT_RESET  = 3,
  parameter int unsigned MODE_COUNT = 4,
  parameter int unsigned MODE_W     = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              act_vld,
  input  action_t           act_code,
  output logic [OCT_W-1:0]  octave,
  output logic [MODE_W-1:0] mode,
  output logic              goof_en
);

  logic [OCT_W-1:0]  octave_q, octave_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              goof_en_q, goof_en_d;

  always_comb begin
    octave_d  = octave_q;
    mode_d    = mode_q;
    goof_en_d = goof_en_q;
    if (act_vld) begin
      case (act_code)
        ACT_UP: begin
          if (octave_q < OCT_W'(OCT_MAX)) octave_d = octave_q + OCT_W'(1);
        end
        ACT_DOWN: begin
          if (octave_q != '0) octave_d = octave_q - OCT_W'(1);
        end
        ACT_MODE: begin
          if (mode_q == MODE_W'(MODE_COUNT - 1)) mode_d = '0;
          else                                   mode_d = mode_q + MODE_W'(1);
        end
        ACT_GOOF: goof_en_d = ~goof_en_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      octave_q  <= OCT_W'(OCT_RESET);
      mode_q    <= '0;
      goof_en_q <= 1'b0;
    end else begin
      octave_q  <= octave_d;
      mode_q    <= mode_d;
      goof_en_q <= goof_en_d;
    end
  end

  assign octave  = octave_q;
  assign mode    = mode_q;
  assign goof_en = goof_en_q;

endmodule

// File: rtl/key_event_decoder.sv
// Turns held keypad flags/keycode into note_on/note_off pulses and control actions; OCTAVE_REPEAT_EN adds octave auto-repeat.
// Latency: all outputs registered, 1 cycle after the input change; no backpressure (inputs sampled every cycle).
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned OCT_W         = 3,
  parameter int unsigned OCT_MAX       = 6,
  parameter int unsigned OCT_RESET     = 3,
  parameter int unsigned MODE_COUNT    = 4,
  parameter int unsigned MODE_W        = 2,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              octave_key_up,
  input  logic              octave_key_down,
  input  logic              mode_key,
  input  logic              goof_key,
  input  logic [3:0]        keycode,
  input  logic              strobe,
  output logic              note_on,
  output logic              note_off,
  output logic              note_active,
  output logic [3:0]        note_code,
  output logic [OCT_W-1:0]  octave,
  output logic [MODE_W-1:0] mode,
  output logic              goof_en
);

  state_t     state_q, state_d;
  action_t    win_q, win_d;
  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  logic       note_active_q, note_active_d;
  logic [3:0] note_code_q, note_code_d;

  logic    ctrl;
  logic    note_key;
  action_t win;
  logic    act_vld;
  logic    rpt_fire;

  assign ctrl     = octave_key_up | octave_key_down | mode_key | goof_key;
  assign note_key = strobe & ~ctrl & (keycode <= NOTE_MAX);
  assign win      = pick_action(octave_key_up, octave_key_down, mode_key, goof_key);

`ifdef OCTAVE_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_held;

  // Counting only while the same up/down flag keeps winning; anything else restarts the interval.
  always_comb begin
    rpt_held  = (state_q == CTRL_HELD) && (win == win_q) &&
                ((win == ACT_UP) || (win == ACT_DOWN));
    rpt_fire  = rpt_held && (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1));
    rpt_cnt_d = (rpt_held && !rpt_fire) ? rpt_cnt_q + RPT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) rpt_cnt_q <= '0;
    else       rpt_cnt_q <= rpt_cnt_d;
  end
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = (REPEAT_CYCLES == 0);
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    note_on_d     = 1'b0;
    note_off_d    = 1'b0;
    note_active_d = note_active_q;
    note_code_d   = note_code_q;
    act_vld       = 1'b0;

    case (state_q)
      IDLE: begin
        if (note_key) begin
          state_d       = NOTE_HELD;
          note_on_d     = 1'b1;
          note_active_d = 1'b1;
          note_code_d   = keycode;
        end else if (ctrl) begin
          state_d = CTRL_HELD;
          win_d   = win;
          act_vld = 1'b1;
        end
      end

      NOTE_HELD: begin
        if (ctrl) begin
          state_d       = CTRL_HELD;
          win_d         = win;
          act_vld       = 1'b1;
          note_off_d    = 1'b1;
          note_active_d = 1'b0;
        end else if (!note_key) begin
          state_d       = IDLE;
          note_off_d    = 1'b1;
          note_active_d = 1'b0;
        end else if (keycode != note_code_q) begin
          // Direct key change: close the old note and open the new one together.
          note_off_d  = 1'b1;
          note_on_d   = 1'b1;
          note_code_d = keycode;
        end
      end

      CTRL_HELD: begin
        if (ctrl) begin
          if (win != win_q) begin
            win_d   = win;
            act_vld = 1'b1;
          end else if (rpt_fire) begin
            act_vld = 1'b1;
          end
        end else if (note_key) begin
          state_d       = NOTE_HELD;
          note_on_d     = 1'b1;
          note_active_d = 1'b1;
          note_code_d   = keycode;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= IDLE;
      win_q         <= ACT_NONE;
      note_on_q     <= 1'b0;
      note_off_q    <= 1'b0;
      note_active_q <= 1'b0;
      note_code_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      note_on_q     <= note_on_d;
      note_off_q    <= note_off_d;
      note_active_q <= note_active_d;
      note_code_q   <= note_code_d;
    end
  end

  key_action_regs #(
    .OCT_W      (OCT_W),
    .OCT_MAX    (OCT_MAX),
    .OCT_RESET  (OCT_RESET),
    .MODE_COUNT (MODE_COUNT),
    .MODE_W     (MODE_W)
  ) u_action_regs (
    .clk      (clk),
    .nrst     (nrst),
    .act_vld  (act_vld),
    .act_code (win),
    .octave   (octave),
    .mode     (mode),
    .goof_en  (goof_en)
  );

  assign note_on     = note_on_q;
  assign note_off    = note_off_q;
  assign note_active = note_active_q;
  assign note_code   = note_code_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Table-driven bench for key_event_decoder: each step drives inputs, queues the expected
// registered outputs and compares them one clock later.
module tb_key_event_decoder;

  logic       clk = 1'b0;
  logic       nrst;
  logic       octave_key_up, octave_key_down, mode_key, goof_key, strobe;
  logic [3:0] keycode;
  logic       note_on, note_off, note_active, goof_en;
  logic [3:0] note_code;
  logic [2:0] octave;
  logic [1:0] mode;

  // exp layout: {note_on, note_off, note_active, note_code[3:0], octave[2:0], mode[1:0], goof_en}
  typedef struct {
    string       nm;
    logic        rn, up, dn, md, gf, s;
    logic [3:0]  k;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  key_event_decoder #(.REPEAT_CYCLES(4)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .octave_key_up   (octave_key_up),
    .octave_key_down (octave_key_down),
    .mode_key        (mode_key),
    .goof_key        (goof_key),
    .keycode         (keycode),
    .strobe          (strobe),
    .note_on         (note_on),
    .note_off        (note_off),
    .note_active     (note_active),
    .note_code       (note_code),
    .octave          (octave),
    .mode            (mode),
    .goof_en         (goof_en)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] pk(input logic on, input logic off, input logic act,
                                     input logic [3:0] code, input logic [2:0] oct,
                                     input logic [1:0] md, input logic ge);
    return {on, off, act, code, oct, md, ge};
  endfunction

  function automatic vec_t mk(input string nm, input logic rn, input logic up, input logic dn,
                              input logic md, input logic gf, input logic s,
                              input logic [3:0] k, input logic [12:0] exp);
    vec_t v;
    v.nm = nm; v.rn = rn; v.up = up; v.dn = dn; v.md = md; v.gf = gf;
    v.s = s; v.k = k; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [12:0] got, want;
    nrst = v.rn; octave_key_up = v.up; octave_key_down = v.dn;
    mode_key = v.md; goof_key = v.gf; strobe = v.s; keycode = v.k;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    got  = {note_on, note_off, note_active, note_code, octave, mode, goof_en};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got on=%b off=%b act=%b code=%0d oct=%0d mode=%0d goof=%b, want on=%b off=%b act=%b code=%0d oct=%0d mode=%0d goof=%b",
               v.nm, got[12], got[11], got[10], got[9:6], got[5:3], got[2:1], got[0],
               want[12], want[11], want[10], want[9:6], want[5:3], want[2:1], want[0]);
    end
  endtask

  initial begin
    int   o, m, n;
    logic g;
    nrst = 1'b0; octave_key_up = 1'b0; octave_key_down = 1'b0;
    mode_key = 1'b0; goof_key = 1'b0; strobe = 1'b0; keycode = 4'd0;

    // Reset, single note, direct key change, invalid codes.
    vecs.push_back(mk("rst",      0, 0,0,0,0, 0, 4'd0,  pk(0,0,0,4'd0,3'd3,2'd0,0)));
    vecs.push_back(mk("idle",     1, 0,0,0,0, 0, 4'd0,  pk(0,0,0,4'd0,3'd3,2'd0,0)));
    vecs.push_back(mk("n5_on",    1, 0,0,0,0, 1, 4'd5,  pk(1,0,1,4'd5,3'd3,2'd0,0)));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("n5_hold", 1, 0,0,0,0, 1, 4'd5, pk(0,0,1,4'd5,3'd3,2'd0,0)));
    vecs.push_back(mk("n5_off",   1, 0,0,0,0, 0, 4'd0,  pk(0,1,0,4'd5,3'd3,2'd0,0)));
    vecs.push_back(mk("n5_idle",  1, 0,0,0,0, 0, 4'd0,  pk(0,0,0,4'd5,3'd3,2'd0,0)));
    vecs.push_back(mk("n2_on",    1, 0,0,0,0, 1, 4'd2,  pk(1,0,1,4'd2,3'd3,2'd0,0)));
    vecs.push_back(mk("n2_hold",  1, 0,0,0,0, 1, 4'd2,  pk(0,0,1,4'd2,3'd3,2'd0,0)));
    vecs.push_back(mk("swap_9",   1, 0,0,0,0, 1, 4'd9,  pk(1,1,1,4'd9,3'd3,2'd0,0)));
    vecs.push_back(mk("n9_hold",  1, 0,0,0,0, 1, 4'd9,  pk(0,0,1,4'd9,3'd3,2'd0,0)));
    vecs.push_back(mk("n9_off",   1, 0,0,0,0, 0, 4'd0,  pk(0,1,0,4'd9,3'd3,2'd0,0)));
    vecs.push_back(mk("inv_idle", 1, 0,0,0,0, 1, 4'd13, pk(0,0,0,4'd9,3'd3,2'd0,0)));
    vecs.push_back(mk("n4_on",    1, 0,0,0,0, 1, 4'd4,  pk(1,0,1,4'd4,3'd3,2'd0,0)));
    vecs.push_back(mk("inv_off",  1, 0,0,0,0, 1, 4'd14, pk(0,1,0,4'd4,3'd3,2'd0,0)));
    vecs.push_back(mk("idle2",    1, 0,0,0,0, 0, 4'd0,  pk(0,0,0,4'd4,3'd3,2'd0,0)));

    // Octave presses: saturate at 6 going up, at 0 going down.
    o = 3; m = 0; g = 1'b0;
    for (int p = 0; p < 5; p++) begin
      o = (o < 6) ? o + 1 : 6;
      vecs.push_back(mk("oct_up",     1, 1,0,0,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
      vecs.push_back(mk("oct_up_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    end
    for (int p = 0; p < 8; p++) begin
      o = (o > 0) ? o - 1 : 0;
      vecs.push_back(mk("oct_dn",     1, 0,1,0,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
      vecs.push_back(mk("oct_dn_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    end

    // Mode wraps 3 -> 0; goof toggles once per press, even when held long.
    for (int p = 0; p < 5; p++) begin
      m = (m + 1) % 4;
      vecs.push_back(mk("mode",     1, 0,0,1,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
      vecs.push_back(mk("mode_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    end
    for (int p = 0; p < 2; p++) begin
      g = ~g;
      vecs.push_back(mk("goof",     1, 0,0,0,1, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
      vecs.push_back(mk("goof_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    end
    g = 1'b1;
    for (int c = 0; c < 20; c++)
      vecs.push_back(mk("goof_hold", 1, 0,0,0,1, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    vecs.push_back(mk("goof_hold_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));

    // Flag priority and winner changes while held.
    o = 1;
    vecs.push_back(mk("pri_all",     1, 1,1,1,1, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    vecs.push_back(mk("pri_all_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    o = 0;
    vecs.push_back(mk("pri_dn_md",   1, 0,1,1,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    vecs.push_back(mk("pri_dn_rel",  1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    m = 2;
    vecs.push_back(mk("pri_md_gf",   1, 0,0,1,1, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    vecs.push_back(mk("pri_md_rel",  1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    m = 3;
    vecs.push_back(mk("chg_md",      1, 0,0,1,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    o = 1;
    vecs.push_back(mk("chg_md_up",   1, 1,0,1,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    m = 0;
    vecs.push_back(mk("chg_md_back", 1, 0,0,1,0, 1, 4'd3, pk(0,0,0,4'd4,3'(o),2'(m),g)));
    vecs.push_back(mk("chg_rel",     1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd4,3'(o),2'(m),g)));

    // Note interrupted by a control key, resumed on release.
    vecs.push_back(mk("n7_on",       1, 0,0,0,0, 1, 4'd7, pk(1,0,1,4'd7,3'(o),2'(m),g)));
    vecs.push_back(mk("n7_hold",     1, 0,0,0,0, 1, 4'd7, pk(0,0,1,4'd7,3'(o),2'(m),g)));
    m = 1;
    vecs.push_back(mk("n7_mode",     1, 0,0,1,0, 1, 4'd7, pk(0,1,0,4'd7,3'(o),2'(m),g)));
    vecs.push_back(mk("n7_mode_hold",1, 0,0,1,0, 1, 4'd7, pk(0,0,0,4'd7,3'(o),2'(m),g)));
    vecs.push_back(mk("n7_resume",   1, 0,0,0,0, 1, 4'd7, pk(1,0,1,4'd7,3'(o),2'(m),g)));
    vecs.push_back(mk("n7_hold2",    1, 0,0,0,0, 1, 4'd7, pk(0,0,1,4'd7,3'(o),2'(m),g)));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset while a note is held: straight to reset values, no trailing note_off.
    apply(mk("rst_mid",    0, 0,0,0,0, 1, 4'd7, pk(0,0,0,4'd0,3'd3,2'd0,0)));
    apply(mk("rst_no_off", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd0,3'd3,2'd0,0)));

    // Octave-up held 13 cycles from 3: repeats every 4 cycles only with the repeat build.
    o = 3;
    for (n = 0; n < 13; n++) begin
`ifdef OCTAVE_REPEAT_EN
      o = (4 + n / 4 > 6) ? 6 : 4 + n / 4;
`else
      o = 4;
`endif
      apply(mk("up_hold", 1, 1,0,0,0, 1, 4'd0, pk(0,0,0,4'd0,3'(o),2'd0,0)));
    end
    apply(mk("up_hold_rel", 1, 0,0,0,0, 0, 4'd0, pk(0,0,0,4'd0,3'(o),2'd0,0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
